datapath_sequencer: RTL and testbench

//  Instruction-level controller for the 8-bit register-file/ALU datapath.
//  - Accepts one 16-bit instruction at a time over a valid/ready handshake.
//  - Decodes it into the datapath control set: write enable, input-mux

---
 rtl/datapath_sequencer.sv | 121 ++++++++++++
 tb/tb_datapath_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | datapath_sequencer                                                       |
// | Decodes one 16-bit instruction per handshake into register-file/ALU      |
// | control and walks it through an EXEC -> WRITE -> retire sequence.         |
// | Optional build macro: DP_SEQ_ILLEGAL_TRAP_EN (sticky reserved-op trap).   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module datapath_sequencer #(
    parameter int         DATA_W     = 8,
    parameter int         REG_AW     = 4,
    parameter int         OP_W       = 4,
    parameter logic [3:0] LDI_OPCODE = 4'hF,
    parameter int         NUM_ALU_OP = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              instr_done,
    output logic              illegal,
    output logic              write_en,
    output logic              mux_sel,
    output logic [DATA_W-1:0] input_data,
    output logic [REG_AW-1:0] dst_sel,
    output logic [REG_AW-1:0] a_sel,
    output logic [REG_AW-1:0] b_sel,
    output logic [OP_W-1:0]   op_sel
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_wr_ok;
    logic [3:0] w_op;
    logic       w_is_ldi;
    logic       w_is_alu;

    assign w_op     = instr[15:12];
    assign w_is_ldi = (w_op == LDI_OPCODE);
    assign w_is_alu = ({28'd0, w_op} < NUM_ALU_OP);

    // Registered outputs; async reset clears write_en at once, aborting any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ok     <= 1'b0;
            instr_ready <= 1'b1;
            instr_done  <= 1'b0;
            write_en    <= 1'b0;
            mux_sel     <= 1'b0;
            input_data  <= '0;
            dst_sel     <= '0;
            a_sel       <= '0;
            b_sel       <= '0;
            op_sel      <= '0;
        end else begin
            instr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        r_state     <= S_EXEC;
                        instr_ready <= 1'b0;
                        r_wr_ok     <= w_is_ldi | w_is_alu;
                        dst_sel     <= REG_AW'(instr[11:8]);
                        input_data  <= DATA_W'(instr[7:0]);
                        if (w_is_ldi) begin
                            mux_sel <= 1'b1;
                            a_sel   <= '0;
                            b_sel   <= '0;
                            op_sel  <= '0;
                        end else begin
                            mux_sel <= 1'b0;
                            a_sel   <= REG_AW'(instr[7:4]);
                            b_sel   <= REG_AW'(instr[3:0]);
                            op_sel  <= OP_W'(w_op);
                        end
                    end
                end
                S_EXEC: begin
                    r_state  <= S_WRITE;
                    write_en <= r_wr_ok;
                end
                S_WRITE: begin
                    r_state     <= S_IDLE;
                    write_en    <= 1'b0;
                    // A trapped instruction never retires and leaves the port closed.
                    instr_ready <= ~illegal;
                    instr_done  <= ~illegal;
                end
                default: begin
                    r_state  <= S_IDLE;
                    write_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef DP_SEQ_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_EXEC && !r_wr_ok) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// Testbench for datapath_sequencer: random instruction streams against an
// instruction-level model with a small register-file/ALU stand-in.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        instr_ready, instr_done, illegal, write_en, mux_sel;
    logic [7:0]  input_data;
    logic [3:0]  dst_sel, a_sel, b_sel, op_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    datapath_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_done(instr_done), .illegal(illegal),
        .write_en(write_en), .mux_sel(mux_sel), .input_data(input_data),
        .dst_sel(dst_sel), .a_sel(a_sel), .b_sel(b_sel), .op_sel(op_sel)
    );

    function automatic logic [7:0] tb_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return a;
            4'd1:    return a & b;
            4'd2:    return a | b;
            4'd3:    return a ^ b;
            4'd4:    return a + b;
            4'd5:    return a - b;
            4'd6:    return ~a;
            4'd7:    return a << 1;
            4'd8:    return a >> 1;
            4'd9:    return b;
            default: return 8'h00;
        endcase
    endfunction

    // Datapath stand-in driven purely by the sequencer's control outputs.
    logic [7:0] dp_regs [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (write_en)
            dp_regs[dst_sel] <= mux_sel ? input_data : tb_alu(op_sel, dp_regs[a_sel], dp_regs[b_sel]);
    end

    logic [7:0] model_regs [16] = '{default: 8'h00};

    function automatic void model_exec(input logic [15:0] ins);
        logic [3:0] op;
        op = ins[15:12];
        if (op == 4'hF)
            model_regs[ins[11:8]] = ins[7:0];
        else if (op < 4'd10)
            model_regs[ins[11:8]] = tb_alu(op, model_regs[ins[7:4]], model_regs[ins[3:0]]);
    endfunction

    // {mux_sel, input_data, dst_sel, a_sel, b_sel, op_sel}
    function automatic logic [24:0] exp_ctrl(input logic [15:0] ins);
        if (ins[15:12] == 4'hF)
            return {1'b1, ins[7:0], ins[11:8], 12'h000};
        return {1'b0, 8'h00, ins[11:8], ins[7:4], ins[3:0], ins[15:12]};
    endfunction

    function automatic logic [24:0] ctrl_mask(input logic [15:0] ins);
        return (ins[15:12] == 4'hF) ? 25'h1FFFFFF : 25'h100FFFF;
    endfunction

    function automatic logic [24:0] ctrl_now();
        return {mux_sel, input_data, dst_sel, a_sel, b_sel, op_sel};
    endfunction

    logic        obs_rdy0, obs_rdy_end;
    logic [2:0]  obs_we, obs_done, obs_ill;
    logic [24:0] obs_ctrl [3];

    // Offers one instruction and records the three following cycles.
    task automatic drive_instr(input logic [15:0] ins);
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        #1 obs_rdy0 = instr_ready;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        instr = 16'($urandom);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            obs_we[k]   = write_en;
            obs_done[k] = instr_done;
            obs_ill[k]  = illegal;
            obs_ctrl[k] = ctrl_now();
        end
        obs_rdy_end = instr_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_valid = 1'b1;
        instr = 16'hF0AA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({instr_ready, write_en, instr_done, illegal} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags got=%b want=1000", {instr_ready, write_en, instr_done, illegal}); end
        checks++; if (ctrl_now() !== 25'h0) begin
            errors++; $display("FAIL reset_buses got=%h want=0", ctrl_now()); end
        instr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({instr_ready, write_en, instr_done} !== 3'b100 || ctrl_now() !== 25'h0) begin
            errors++; $display("FAIL reset_release got=%b/%h want=100/0", {instr_ready, write_en, instr_done}, ctrl_now()); end
    endtask

    task automatic test_ldi();
        drive_instr(16'hF002);
        model_exec(16'hF002);
        checks++; if (obs_rdy0 !== 1'b1) begin
            errors++; $display("FAIL ldi_ready got=%b want=1", obs_rdy0); end
        checks++; if (obs_we !== 3'b010) begin
            errors++; $display("FAIL ldi_write_en got=%b want=010", obs_we); end
        checks++; if (obs_done !== 3'b100 || obs_rdy_end !== 1'b1) begin
            errors++; $display("FAIL ldi_done got=%b/%b want=100/1", obs_done, obs_rdy_end); end
        checks++; if (obs_ctrl[1] !== exp_ctrl(16'hF002) || obs_ctrl[0] !== obs_ctrl[1]) begin
            errors++; $display("FAIL ldi_ctrl got=%h want=%h", obs_ctrl[1], exp_ctrl(16'hF002)); end
        checks++; if (dp_regs[0] !== 8'd2) begin
            errors++; $display("FAIL ldi_reg0 got=%0d want=2", dp_regs[0]); end
    endtask

    task automatic test_add();
        drive_instr(16'hF002); model_exec(16'hF002);
        drive_instr(16'hF104); model_exec(16'hF104);
        drive_instr(16'h4F01); model_exec(16'h4F01);
        checks++; if (obs_we !== 3'b010 || obs_done !== 3'b100) begin
            errors++; $display("FAIL add_timing got=%b/%b want=010/100", obs_we, obs_done); end
        checks++; if ((obs_ctrl[1] & 25'h100FFFF) !== exp_ctrl(16'h4F01)) begin
            errors++; $display("FAIL add_ctrl got=%h want=%h", obs_ctrl[1] & 25'h100FFFF, exp_ctrl(16'h4F01)); end
        checks++; if (dp_regs[15] !== 8'd6 || model_regs[15] !== 8'd6) begin
            errors++; $display("FAIL add_reg15 got=%0d want=6", dp_regs[15]); end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        int r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 10);
            ins = {(r == 10) ? 4'hF : 4'(r), 12'($urandom)};
            drive_instr(ins);
            model_exec(ins);
            checks++; if (obs_rdy0 !== 1'b1 || obs_we !== 3'b010 || obs_done !== 3'b100) begin
                errors++; $display("FAIL rand_timing ins=%h got=%b/%b/%b want=1/010/100", ins, obs_rdy0, obs_we, obs_done); end
            checks++; if ((obs_ctrl[1] & ctrl_mask(ins)) !== exp_ctrl(ins) || obs_ctrl[0] !== obs_ctrl[1]) begin
                errors++; $display("FAIL rand_ctrl ins=%h got=%h want=%h", ins, obs_ctrl[1] & ctrl_mask(ins), exp_ctrl(ins)); end
            checks++; if (dp_regs[ins[11:8]] !== model_regs[ins[11:8]]) begin
                errors++; $display("FAIL rand_reg ins=%h got=%h want=%h", ins, dp_regs[ins[11:8]], model_regs[ins[11:8]]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] list [3];
        logic [11:0] acc_m, we_m, done_m;
        logic        acc;
        int          idx;
        for (int i = 0; i < 3; i++)
            list[i] = {4'(($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 9)), 12'($urandom)};
        acc_m = '0; we_m = '0; done_m = '0; idx = 0;
        @(negedge clk);
        instr = list[0];
        instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            acc = instr_valid & instr_ready;
            acc_m[c]  = acc;
            we_m[c]   = write_en;
            done_m[c] = instr_done;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) instr = list[idx];
                else instr_valid = 1'b0;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) model_exec(list[i]);
        checks++; if (acc_m !== 12'h049) begin
            errors++; $display("FAIL b2b_accept got=%h want=049", acc_m); end
        checks++; if (we_m !== 12'h124) begin
            errors++; $display("FAIL b2b_write_en got=%h want=124", we_m); end
        checks++; if (done_m !== 12'h248) begin
            errors++; $display("FAIL b2b_done got=%h want=248", done_m); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dp_regs[i] !== model_regs[i]) begin
                errors++; $display("FAIL b2b_reg%0d got=%h want=%h", i, dp_regs[i], model_regs[i]); end
        end
    endtask

    task automatic test_reset_abort();
        drive_instr(16'hFEA5); model_exec(16'hFEA5);
        drive_instr(16'hF003); model_exec(16'hF003);
        drive_instr(16'hF105); model_exec(16'hF105);
        @(negedge clk);
        instr = 16'h4E01;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (write_en !== 1'b1) begin
            errors++; $display("FAIL abort_pre_we got=%b want=1", write_en); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (write_en !== 1'b0 || instr_ready !== 1'b1) begin
            errors++; $display("FAIL abort_async got=%b/%b want=0/1", write_en, instr_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (dp_regs[14] !== 8'hA5 || model_regs[14] !== 8'hA5) begin
            errors++; $display("FAIL abort_reg14 got=%h want=a5", dp_regs[14]); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({instr_ready, write_en, instr_done} !== 3'b100) begin
            errors++; $display("FAIL abort_idle got=%b want=100", {instr_ready, write_en, instr_done}); end
    endtask

    task automatic test_reserved();
        logic [15:0] ins;
        for (int n = 0; n < 3; n++) begin
            ins = (n == 0) ? 16'hA123 : {4'($urandom_range(10, 14)), 12'($urandom)};
            drive_instr(ins);
            checks++; if (obs_we !== 3'b000) begin
                errors++; $display("FAIL rsv_write_en ins=%h got=%b want=000", ins, obs_we); end
`ifdef DP_SEQ_ILLEGAL_TRAP_EN
            checks++; if (obs_ill[1] !== 1'b1 || obs_done !== 3'b000 || obs_rdy_end !== 1'b0) begin
                errors++; $display("FAIL rsv_trap got=%b/%b/%b want=1/000/0", obs_ill[1], obs_done, obs_rdy_end); end
            drive_instr(16'hF0FF);
            checks++; if (obs_rdy0 !== 1'b0 || obs_we !== 3'b000 || illegal !== 1'b1) begin
                errors++; $display("FAIL rsv_parked got=%b/%b/%b want=0/000/1", obs_rdy0, obs_we, illegal); end
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            checks++; if (illegal !== 1'b0 || instr_ready !== 1'b1) begin
                errors++; $display("FAIL rsv_reset got=%b/%b want=0/1", illegal, instr_ready); end
`else
            checks++; if (obs_done !== 3'b100 || obs_rdy_end !== 1'b1 || obs_ill !== 3'b000) begin
                errors++; $display("FAIL rsv_nop got=%b/%b/%b want=100/1/000", obs_done, obs_rdy_end, obs_ill); end
`endif
            for (int i = 0; i < 16; i++) begin
                checks++; if (dp_regs[i] !== model_regs[i]) begin
                    errors++; $display("FAIL rsv_reg%0d got=%h want=%h", i, dp_regs[i], model_regs[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_add();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_reserved();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
